argmax_classifier: RTL and testbench
====================================

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 Parameter: NUM_CLASSES, 10, number of features per vector received from the final dense layer; legal range 2..256.
REQ-002 Parameter: MARGIN_WIDTH, 16, bit width of the margin output.
REQ-003 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: features_in  feature_if  -  consumer side: valid in, ready out, features[0] in (feature_type, signed two's complement per mnist_pkg).
REQ-006 Port: class_out  output  $clog2(NUM_CLASSES)  index of the winning feature.
REQ-007 Port: margin_out  output  MARGIN_WIDTH  winner value minus runner-up value, unsigned, saturated.
REQ-008 Port: class_valid  output  1  class_out/margin_out hold a result.
REQ-009 Port: class_ready  input  1  downstream accepts the result.

Function
REQ-010 The block SHALL implement two states, COLLECT and PRESENT; reset enters COLLECT.
REQ-011 In COLLECT, features_in.ready SHALL be 1 and class_valid 0; in PRESENT, features_in.ready SHALL be 0 and class_valid 1.
REQ-012 A beat SHALL be accepted only on a rising edge where features_in.valid and features_in.ready are both 1; each accepted beat increments an index counter from 0.
REQ-013 On beat index 0, best value/index SHALL load from the beat, and second-best value SHALL load with the most negative feature_type value.
REQ-014 On beat index k>0, if value > best (signed compare): second <= best, best <= value, best index <= k; else if value > second: second <= value; otherwise no change.
REQ-015 Ties SHALL keep the lower index (strict greater-than compare).
REQ-016 When the beat with index NUM_CLASSES-1 is accepted, the block SHALL move to PRESENT on the same edge with the final comparison already applied; class_valid rises the next cycle (latency 1 cycle after last beat).
REQ-017 margin_out SHALL equal best - second computed at full width plus one bit, saturated to 2^MARGIN_WIDTH-1; all-equal inputs yield margin 0.
REQ-018 class_out and margin_out SHALL remain stable while class_valid is 1 and class_ready is 0.
REQ-019 On an edge with class_valid and class_ready both 1, the block SHALL return to COLLECT, clear the index counter, and be ready for the next vector the following cycle.
REQ-020 Beats presented while in PRESENT SHALL NOT be consumed (ready is 0) and SHALL be taken after return to COLLECT.
REQ-021 Gaps (valid low) between beats SHALL be tolerated without altering state.
REQ-022 The index counter SHALL never exceed NUM_CLASSES-1; no partial-vector timeout exists.
REQ-023 Outputs SHALL be registered; no combinational path from class_ready or features_in.valid to any output.

Reset
REQ-024 Asserting reset_n low SHALL immediately set state COLLECT, index 0, class_valid 0, class_out 0, margin_out 0, best/second to most negative value.
REQ-025 Reset mid-vector SHALL discard the partial vector; the next accepted beat after release is index 0.
REQ-026 features_in.ready SHALL be 1 during and after reset (COLLECT).

Verification
REQ-027 Ten beats 5,3,9,-2,9,0,1,1,7,4 back-to-back, class_ready=1 -> class_out=2, margin_out=0 (tie keeps index 2), class_valid high exactly 1 cycle.
REQ-028 Beats -10,-3,-7,-20,-8,-9,-4,-5,-6,-11 -> class_out=1, margin_out=1 (signed handling).
REQ-029 Valid beats with random 0-3 cycle gaps, class_ready held 0 for 5 cycles after result -> outputs stable 5 cycles, ready stays 0, no beats consumed until handshake.
REQ-030 Winner at index 9 of value max feature_type, all others min feature_type -> class_out=9, margin_out saturated at 2^MARGIN_WIDTH-1 when difference exceeds range.
REQ-031 reset_n pulsed low after 4 beats, then a full fresh vector 0..9 -> class_out=9, margin_out=1; no residue from aborted vector.
REQ-032 Two vectors back-to-back with class_ready=1 -> two results, the second ready-high cycle exactly one cycle after first result handshake.

Source files
------------

// File: rtl/argmax_classifier.sv
// argmax_classifier: streams NUM_CLASSES signed features, reports the winning
// index and the saturated winner/runner-up margin.
//   clock, reset_n          : single clock, async active-low reset
//   features_in (consumer)  : valid in, ready out, features[0] in
//   class_out, margin_out   : registered result
//   class_valid/class_ready : result handshake

package mnist_pkg;
   localparam int FEATURE_W = 16;
   typedef logic signed [FEATURE_W-1:0] feature_type;
   localparam feature_type FEATURE_MIN = {1'b1, {(FEATURE_W-1){1'b0}}};
endpackage

interface feature_if;
   import mnist_pkg::*;
   logic        valid;
   logic        ready;
   feature_type features [0:0];
   modport consumer (input valid, input features, output ready);
   modport producer (output valid, output features, input ready);
endinterface

module argmax_classifier
   import mnist_pkg::*;
#(
   parameter int NUM_CLASSES  = 10,
   parameter int MARGIN_WIDTH = 16
) (
   input  logic                           clock,
   input  logic                           reset_n,
   feature_if.consumer                    features_in,
   output logic [$clog2(NUM_CLASSES)-1:0] class_out,
   output logic [MARGIN_WIDTH-1:0]        margin_out,
   output logic                           class_valid,
   input  logic                           class_ready
);

   localparam int IW = $clog2(NUM_CLASSES);
   localparam int DW = FEATURE_W + 1;

   typedef enum logic {
      COLLECT,
      PRESENT
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [IW-1:0]           r_idx;
   logic [IW-1:0]           r_best_idx;
   logic [IW-1:0]           r_class;
   logic [MARGIN_WIDTH-1:0] r_margin;
   feature_type             r_best;
   feature_type             r_second;

   feature_type             w_val;
   feature_type             w_best_n;
   feature_type             w_second_n;
   logic [IW-1:0]           w_idx_n;
   logic [DW-1:0]           w_diff;
   logic [MARGIN_WIDTH-1:0] w_margin;
   logic                    w_accept;
   logic                    w_last;
   logic                    w_release;

   assign w_val     = features_in.features[0];
   assign w_accept  = features_in.valid && (r_state == COLLECT);
   assign w_last    = (r_idx == IW'(NUM_CLASSES - 1));
   assign w_release = (r_state == PRESENT) && class_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= COLLECT;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         COLLECT: if (w_accept && w_last) w_state_nxt = PRESENT;
         PRESENT: if (class_ready)        w_state_nxt = COLLECT;
         default: w_state_nxt = COLLECT;
      endcase
   end

   // Strict compares keep the lower index on ties.
   always_comb begin
      w_best_n   = r_best;
      w_second_n = r_second;
      w_idx_n    = r_best_idx;
      if (r_idx == '0) begin
         w_best_n   = w_val;
         w_second_n = FEATURE_MIN;
         w_idx_n    = '0;
      end else if (w_val > r_best) begin
         w_second_n = r_best;
         w_best_n   = w_val;
         w_idx_n    = r_idx;
      end else if (w_val > r_second) begin
         w_second_n = w_val;
      end
   end

   // best >= second always, so the one-bit-wider difference is non-negative.
   assign w_diff = {w_best_n[FEATURE_W-1], w_best_n}
                 - {w_second_n[FEATURE_W-1], w_second_n};

   generate
      if (MARGIN_WIDTH >= DW) begin : g_wide
         assign w_margin = MARGIN_WIDTH'(w_diff);
      end else begin : g_sat
         assign w_margin = (|w_diff[DW-1:MARGIN_WIDTH])
                         ? '1 : w_diff[MARGIN_WIDTH-1:0];
      end
   endgenerate

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_idx      <= '0;
         r_best     <= FEATURE_MIN;
         r_second   <= FEATURE_MIN;
         r_best_idx <= '0;
         r_class    <= '0;
         r_margin   <= '0;
      end else if (w_accept) begin
         r_best     <= w_best_n;
         r_second   <= w_second_n;
         r_best_idx <= w_idx_n;
         r_idx      <= w_last ? '0 : r_idx + 1'b1;
         if (w_last) begin
            r_class  <= w_idx_n;
            r_margin <= w_margin;
         end
      end else if (w_release) begin
         r_idx <= '0;
      end
   end

   assign features_in.ready = (r_state == COLLECT);
   assign class_valid       = (r_state == PRESENT);
   assign class_out         = r_class;
   assign margin_out        = r_margin;

endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier: directed vectors with hand-computed class/margin.
// A second instance (2 classes, 8-bit margin) covers margin saturation.

module tb_argmax_classifier;

   logic        clock;
   logic        reset_n;
   logic [3:0]  cls;
   logic [15:0] mg;
   logic        cv;
   logic        cr;
   logic [0:0]  cls_s;
   logic [7:0]  mg_s;
   logic        cv_s;
   logic        cr_s;

   int vecs = 0;
   int errs = 0;

   feature_if fi ();
   feature_if fs ();

   argmax_classifier #(.NUM_CLASSES(10), .MARGIN_WIDTH(16)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .features_in (fi),
      .class_out   (cls),
      .margin_out  (mg),
      .class_valid (cv),
      .class_ready (cr)
   );

   argmax_classifier #(.NUM_CLASSES(2), .MARGIN_WIDTH(8)) dut_s (
      .clock       (clock),
      .reset_n     (reset_n),
      .features_in (fs),
      .class_out   (cls_s),
      .margin_out  (mg_s),
      .class_valid (cv_s),
      .class_ready (cr_s)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send_vec(input int v [10], input int g [10]);
      for (int i = 0; i < 10; i++) begin
         fi.valid       = 1'b1;
         fi.features[0] = 16'(v[i]);
         @(posedge clock); #1;
         fi.valid = 1'b0;
         for (int k = 0; k < g[i]; k++) begin
            @(posedge clock); #1;
         end
      end
   endtask

   task automatic send2(input int a, input int b);
      fs.valid       = 1'b1;
      fs.features[0] = 16'(a);
      @(posedge clock); #1;
      fs.features[0] = 16'(b);
      @(posedge clock); #1;
      fs.valid = 1'b0;
   endtask

   int z [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

   initial begin
      reset_n        = 1'b0;
      fi.valid       = 1'b0;
      fi.features[0] = '0;
      fs.valid       = 1'b0;
      fs.features[0] = '0;
      cr             = 1'b1;
      cr_s           = 1'b1;

      #12;
      chk("rst_ready", fi.ready, 1);
      chk("rst_valid", cv, 0);
      chk("rst_class", cls, 0);
      chk("rst_margin", mg, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      chk("post_rst_ready", fi.ready, 1);

      // tie keeps index 2
      send_vec('{5, 3, 9, -2, 9, 0, 1, 1, 7, 4}, z);
      chk("tie_valid", cv, 1);
      chk("tie_class", cls, 2);
      chk("tie_margin", mg, 0);
      chk("tie_ready", fi.ready, 0);
      @(posedge clock); #1;
      chk("tie_valid_1cyc", cv, 0);
      chk("tie_ready_back", fi.ready, 1);

      // all negative
      send_vec('{-10, -3, -7, -20, -8, -9, -4, -5, -6, -11}, z);
      chk("neg_class", cls, 1);
      chk("neg_margin", mg, 1);
      @(posedge clock); #1;

      // gaps, then held result with a pending beat
      cr = 1'b0;
      send_vec('{4, -6, 30, 12, -1, 25, 0, 11, 3, -9},
               '{1, 0, 3, 2, 0, 1, 3, 0, 2, 0});
      chk("gap_valid", cv, 1);
      chk("gap_class", cls, 2);
      chk("gap_margin", mg, 5);
      fi.valid       = 1'b1;
      fi.features[0] = 16'sd99;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         chk("hold_valid", cv, 1);
         chk("hold_class", cls, 2);
         chk("hold_margin", mg, 5);
         chk("hold_ready", fi.ready, 0);
      end
      cr = 1'b1;
      @(posedge clock); #1;
      chk("hs_valid", cv, 0);
      chk("hs_ready", fi.ready, 1);
      send_vec('{99, -1, -2, -3, -4, -5, -6, -7, -8, -9}, z);
      chk("pend_class", cls, 0);
      chk("pend_margin", mg, 100);
      @(posedge clock); #1;

      // extreme values
      send_vec('{-32768, -32768, -32768, -32768, -32768,
                 -32768, -32768, -32768, -32768, 32767}, z);
      chk("ext_class", cls, 9);
      chk("ext_margin", mg, 65535);
      @(posedge clock); #1;

      // reset mid-vector
      for (int i = 1; i <= 4; i++) begin
         fi.valid       = 1'b1;
         fi.features[0] = 16'(i * 100);
         @(posedge clock); #1;
      end
      fi.valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_ready", fi.ready, 1);
      chk("mid_rst_valid", cv, 0);
      chk("mid_rst_class", cls, 0);
      chk("mid_rst_margin", mg, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      send_vec('{0, 1, 2, 3, 4, 5, 6, 7, 8, 9}, z);
      chk("fresh_class", cls, 9);
      chk("fresh_margin", mg, 1);
      @(posedge clock); #1;

      // back-to-back vectors
      send_vec('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}, z);
      chk("b2b_a_class", cls, 9);
      chk("b2b_a_margin", mg, 1);
      chk("b2b_a_ready", fi.ready, 0);
      @(posedge clock); #1;
      chk("b2b_ready_back", fi.ready, 1);
      send_vec('{7, 1, 1, 1, 1, 1, 1, 1, 1, 20}, z);
      chk("b2b_b_valid", cv, 1);
      chk("b2b_b_class", cls, 9);
      chk("b2b_b_margin", mg, 13);
      @(posedge clock); #1;

      // narrow margin instance
      send2(10, 3);
      chk("s_small_valid", cv_s, 1);
      chk("s_small_class", cls_s, 0);
      chk("s_small_margin", mg_s, 7);
      @(posedge clock); #1;
      send2(-32768, 32767);
      chk("s_sat_class", cls_s, 1);
      chk("s_sat_margin", mg_s, 255);
      @(posedge clock); #1;
      send2(100, -200);
      chk("s_sat2_class", cls_s, 0);
      chk("s_sat2_margin", mg_s, 255);
      @(posedge clock); #1;
      send2(255, 0);
      chk("s_edge_margin", mg_s, 255);
      @(posedge clock); #1;
      send2(0, 254);
      chk("s_edge2_class", cls_s, 1);
      chk("s_edge2_margin", mg_s, 254);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
